alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
//
// PURPOSE
// Initiator side of the alu operation/done protocol. Accepts one ALU command at a
// time from the control unit over a valid/ready channel and drives the alu operand
// and opcode inputs. It waits out single-cycle and multi-cycle (MUL/DIV/SQRT) ops
// and returns the captured result and flags on a valid/ready response channel.
// Sits between the control unit and alu, and owns the alu operation/a/b inputs.
//
// PARAMETERS
// TIMEOUT_CYCLES  32        WAIT cycles before abandoning a multi-cycle op (>=2)
// PARK_OP         4'h4      opcode driven to alu when not issuing (AND, operands 0)
// MULTI_MASK      16'h800C  bit n set => opcode n is multi-cycle (MUL, DIV, SQRT)
//
// PORTS
// clk            in   1   clock, rising edge
// reset          in   1   synchronous, active-high reset
// cmd_valid      in   1   command offered
// cmd_ready      out  1   command accepted when cmd_valid & cmd_ready at edge
// cmd_op         in   4   alu opcode
// cmd_a          in   8   operand A
// cmd_b          in   8   operand B
// rsp_valid      out  1   response held until rsp_ready
// rsp_ready      in   1   response consumed when rsp_valid & rsp_ready at edge
// rsp_result     out  8   captured alu result
// rsp_flags      out  8   captured alu flags
// rsp_err        out  1   1 = timeout; result/flags forced 0x00
// alu_operation  out  4   to alu operation
// alu_a          out  8   to alu a
// alu_b          out  8   to alu b
// alu_result     in   8   from alu result
// alu_flags      in   8   from alu flags
// alu_done       in   1   from alu done
// busy           out  1   state != IDLE
// op_count       out  16  responses consumed (incl. errors), wraps 0xFFFF->0x0000
//
// BEHAVIOUR
// - Reset (sync): state=IDLE; rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0,
//   alu_operation=PARK_OP, alu_a=alu_b=0, busy=0, op_count=0. Reset wins over all
//   events, including mid-WAIT; the alu shares reset, so no drain is attempted.
// - cmd_ready = (state==IDLE) & alu_done (combinational). All other outputs registered.
// - FSM:
//   IDLE : on cmd handshake latch op/a/b, set multi = MULTI_MASK[cmd_op] -> ISSUE.
//   ISSUE: exactly one cycle with alu_operation/a/b = latched values -> WAIT, wcnt=0.
//   WAIT : alu_operation=PARK_OP, alu_a=alu_b=0; wcnt increments every cycle.
//          single-cycle op: capture alu_result/alu_flags at end of first WAIT cycle.
//          multi-cycle op: ignore alu_done while wcnt==0 (alu drops done there).
//          For wcnt>=1, capture at the end of the first cycle with alu_done=1.
//          Capture -> RESP, rsp_err=0. If wcnt reaches TIMEOUT_CYCLES-1 without
//          capture -> RESP, rsp_err=1, rsp_result=0, rsp_flags=0.
//   RESP : rsp_valid=1, payload stable; on rsp handshake -> IDLE, rsp_valid=0,
//          op_count+1. No new command is accepted while in RESP.
// - Single-cycle latency: cmd handshake edge E -> ISSUE(E+1) -> WAIT(E+2) ->
//   rsp_valid high from E+3.
// - Multi-cycle latency: rsp_valid rises one cycle after the first cycle in WAIT
//   (wcnt>=1) where alu_done is sampled high.
// - Opcode not in MULTI_MASK is treated as single-cycle, with no check of alu_done.
// - PARK_OP side effects on alu result/flags after capture are irrelevant; only
//   captured values are returned.
// - No pipelining: at most one command in flight; the back-to-back issue rate is
//   one command per 4 cycles minimum.
//
// TESTING (behavioural alu stub with programmable done-low duration)
// - ADD a=0x7F b=0x01, stub result 0x80 flags 0x14, rsp_ready=1 -> rsp_valid at
//   E+3 with result 0x80, flags 0x14, err 0; alu_operation=0 for exactly 1 cycle.
// - MUL a=5 b=6, stub done low 9 cycles then result 0x1E -> rsp_result 0x1E,
//   captured only after done returns high; pre-done stub values never returned.
// - Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, cmd_ready=0
//   throughout; handshake -> IDLE next cycle, op_count=1.
// - Timeout: DIV with stub holding done=0 -> rsp_err=1, result=0, flags=0, RESP
//   entered after TIMEOUT_CYCLES WAIT cycles; next command completes normally.
// - Reset asserted during WAIT of SQRT -> next cycle IDLE, rsp_valid=0,
//   alu_operation=PARK_OP, op_count=0; cmd_ready=1 once alu_done=1.
// - op_count preset by 0xFFFF back-to-back ADDs (or forced) -> wraps to 0x0000
//   on next handshake; cmd_ready never high while busy=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// Initiator for the alu operation/done protocol: takes one command at a time over
// valid/ready, drives the alu inputs for a single issue cycle and returns the captured result.
module alu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter logic [3:0]  PARK_OP        = 4'h4,
    parameter logic [15:0] MULTI_MASK     = 16'h800C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_result,
    output logic [7:0]  rsp_flags,
    output logic        rsp_err,
    output logic [3:0]  alu_operation,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  alu_flags,
    input  logic        alu_done,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam int unsigned       WCNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_multi;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_rsp_valid;
    logic [7:0]        r_rsp_result;
    logic [7:0]        r_rsp_flags;
    logic              r_rsp_err;
    logic [3:0]        r_alu_op;
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;
    logic              r_busy;
    logic [15:0]       r_op_count;

    logic              w_cmd_fire;
    logic              w_capture;
    logic              w_timeout;

    assign cmd_ready  = (r_state == S_IDLE) & alu_done;
    assign w_cmd_fire = cmd_valid & cmd_ready;

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE:  if (w_cmd_fire) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                // The alu still shows the previous done in the first WAIT cycle, so a
                // multi-cycle op only trusts alu_done from the second cycle onwards.
                if (!r_multi) begin
                    w_capture = 1'b1;
                end else if ((r_wcnt != '0) && alu_done) begin
                    w_capture = 1'b1;
                end
                w_timeout = !w_capture && (r_wcnt == WCNT_LAST);
                if (w_capture || w_timeout) w_next_state = S_RESP;
            end
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: every register here updates with <= so all of them see the pre-edge
    // state; a blocking assignment would leak a new value into later statements.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_multi      <= 1'b0;
            r_wcnt       <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 8'h00;
            r_rsp_flags  <= 8'h00;
            r_rsp_err    <= 1'b0;
            r_alu_op     <= PARK_OP;
            r_alu_a      <= 8'h00;
            r_alu_b      <= 8'h00;
            r_busy       <= 1'b0;
            r_op_count   <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_alu_op <= cmd_op;
                        r_alu_a  <= cmd_a;
                        r_alu_b  <= cmd_b;
                        r_multi  <= MULTI_MASK[cmd_op];
                    end
                end
                S_ISSUE: begin
                    r_alu_op <= PARK_OP;
                    r_alu_a  <= 8'h00;
                    r_alu_b  <= 8'h00;
                    r_wcnt   <= '0;
                end
                S_WAIT: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (w_capture) begin
                        r_rsp_result <= alu_result;
                        r_rsp_flags  <= alu_flags;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                    end else if (w_timeout) begin
                        r_rsp_result <= 8'h00;
                        r_rsp_flags  <= 8'h00;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_result    = r_rsp_result;
    assign rsp_flags     = r_rsp_flags;
    assign rsp_err       = r_rsp_err;
    assign alu_operation = r_alu_op;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign busy          = r_busy;
    assign op_count      = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a timestamp-based transaction model plus an
// alu stub with programmable done-low time, checked every cycle and by directed cases.
module tb_alu_sequencer;

    localparam int         TIMEOUT = 32;
    localparam logic [3:0] PARK    = 4'h4;

    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, alu_done, busy;
    logic [3:0]  cmd_op, alu_operation;
    logic [7:0]  cmd_a, cmd_b, rsp_result, rsp_flags, alu_a, alu_b, alu_result, alu_flags;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    alu_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .PARK_OP       (PARK),
        .MULTI_MASK    (16'h800C)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_done(alu_done),
        .busy(busy), .op_count(op_count)
    );

    // Stimulus knobs set by the main process; the stub derives alu inputs from them.
    logic       k_reset, k_cmd_valid, k_rsp_ready, k_idle_done;
    logic [3:0] k_op;
    logic [7:0] k_a, k_b, k_res, k_flg;
    int         k_delay;

    // Transaction model: one command in flight, described by timestamps.
    int          cyc = 0;
    bit          chk_en = 1'b0;
    bit          m_inflight = 1'b0;
    int          m_e, m_resp, t_delay;
    bit          m_multi;
    logic [3:0]  m_op;
    logic [7:0]  m_a, m_b, t_res, t_flg, e_res, e_flg, m_pay_res, m_pay_flg;
    logic        e_err, m_pay_err;
    logic [15:0] m_count;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply();
        int w;
        reset      = k_reset;
        cmd_valid  = k_cmd_valid;
        cmd_op     = k_op;
        cmd_a      = k_a;
        cmd_b      = k_b;
        rsp_ready  = k_rsp_ready;
        alu_result = 8'($urandom);
        alu_flags  = 8'($urandom);
        alu_done   = k_idle_done;
        if (m_inflight) begin
            alu_done = 1'b1;
            w = cyc - (m_e + 2);
            if (w >= 0) begin
                if (!m_multi) begin
                    if (w == 0) begin
                        alu_result = t_res;
                        alu_flags  = t_flg;
                        alu_done   = 1'($urandom);
                    end
                end else if (w == 0) begin
                    alu_done = (t_delay == 0);
                end else if (w < t_delay) begin
                    alu_done = 1'b0;
                end else begin
                    alu_result = t_res;
                    alu_flags  = t_flg;
                end
            end
        end
    endtask

    task automatic update_model();
        int lat;
        if (reset) begin
            m_inflight = 1'b0;
            m_count    = 16'h0000;
            m_pay_res  = 8'h00;
            m_pay_flg  = 8'h00;
            m_pay_err  = 1'b0;
            chk_en     = 1'b1;
            return;
        end
        if (m_inflight && cyc >= m_resp && rsp_ready) begin
            m_inflight = 1'b0;
            m_count    = m_count + 16'h1;
        end else if (!m_inflight && cmd_valid && alu_done) begin
            m_inflight = 1'b1;
            m_e        = cyc;
            m_op       = cmd_op;
            m_a        = cmd_a;
            m_b        = cmd_b;
            m_multi    = (cmd_op == 4'h2) || (cmd_op == 4'h3) || (cmd_op == 4'hF);
            t_res      = k_res;
            t_flg      = k_flg;
            t_delay    = k_delay;
            if (!m_multi) begin
                m_resp = cyc + 3;
                {e_res, e_flg, e_err} = {t_res, t_flg, 1'b0};
            end else begin
                lat = (t_delay < 1) ? 1 : t_delay;
                if (lat <= TIMEOUT - 1) begin
                    m_resp = cyc + 3 + lat;
                    {e_res, e_flg, e_err} = {t_res, t_flg, 1'b0};
                end else begin
                    m_resp = cyc + 2 + TIMEOUT;
                    {e_res, e_flg, e_err} = {8'h00, 8'h00, 1'b1};
                end
            end
        end
        if (m_inflight && (cyc + 1) == m_resp) begin
            m_pay_res = e_res;
            m_pay_flg = e_flg;
            m_pay_err = e_err;
        end
    endtask

    task automatic tick();
        apply();
        @(posedge clk);
        update_model();
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_inflight);
            check("cmd_ready", cmd_ready, !m_inflight && alu_done);
            check("alu_operation", alu_operation, (m_inflight && cyc == m_e + 1) ? m_op : PARK);
            check("alu_a", alu_a, (m_inflight && cyc == m_e + 1) ? m_a : 8'h00);
            check("alu_b", alu_b, (m_inflight && cyc == m_e + 1) ? m_b : 8'h00);
            check("rsp_valid", rsp_valid, m_inflight && cyc >= m_resp);
            check("rsp_result", rsp_result, m_pay_res);
            check("rsp_flags", rsp_flags, m_pay_flg);
            check("rsp_err", rsp_err, m_pay_err);
            check("op_count", op_count, m_count);
        end
    end

    task automatic quiet();
        k_reset = 1'b0; k_cmd_valid = 1'b0; k_rsp_ready = 1'b1; k_idle_done = 1'b1;
        k_op = 4'h0; k_a = 8'h00; k_b = 8'h00; k_res = 8'h00; k_flg = 8'h00; k_delay = 0;
    endtask

    task automatic offer(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic [7:0] flg, input int dly);
        k_cmd_valid = 1'b1; k_op = op; k_a = a; k_b = b; k_res = res; k_flg = flg; k_delay = dly;
    endtask

    task automatic do_reset();
        k_reset = 1'b1;
        tick();
        tick();
        k_reset = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cycles);
        for (int i = 0; i < max_cycles && rsp_valid !== 1'b1; i++) tick();
        check("wait_rsp_valid", rsp_valid, 1'b1);
    endtask

    task automatic run_add(input logic [7:0] a, input logic [7:0] b);
        offer(4'h0, a, b, a + b, 8'h00, 0);
        tick();
        k_cmd_valid = 1'b0;
        wait_rsp(10);
        tick();
    endtask

    initial begin
        int e;
        quiet();
        do_reset();
        check("reset_op_count", op_count, 16'h0000);
        check("reset_alu_op", alu_operation, PARK);

        // ADD 0x7F+0x01: issue lasts one cycle, response three cycles after handshake.
        offer(4'h0, 8'h7F, 8'h01, 8'h80, 8'h14, 0);
        e = cyc;
        tick();
        k_cmd_valid = 1'b0;
        check("add_issue_op", alu_operation, 4'h0);
        check("add_issue_a", alu_a, 8'h7F);
        tick();
        check("add_wait_op", alu_operation, PARK);
        check("add_wait_valid", rsp_valid, 1'b0);
        tick();
        check("add_latency", cyc - e, 3);
        check("add_valid", rsp_valid, 1'b1);
        check("add_result", rsp_result, 8'h80);
        check("add_flags", rsp_flags, 8'h14);
        check("add_err", rsp_err, 1'b0);
        tick();
        check("add_count", op_count, 16'h0001);

        // MUL 5*6 with done low for 9 WAIT cycles.
        offer(4'h2, 8'd5, 8'd6, 8'h1E, 8'h00, 9);
        e = cyc;
        tick();
        k_cmd_valid = 1'b0;
        wait_rsp(60);
        check("mul_latency", cyc - e, 12);
        check("mul_result", rsp_result, 8'h1E);
        tick();

        // Backpressure: response held while another command is offered.
        do_reset();
        k_rsp_ready = 1'b0;
        offer(4'h1, 8'h09, 8'h03, 8'h06, 8'h01, 0);
        tick();
        offer(4'h0, 8'h11, 8'h22, 8'h33, 8'h00, 0);
        wait_rsp(10);
        repeat (5) begin
            tick();
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_result", rsp_result, 8'h06);
            check("bp_cmd_ready", cmd_ready, 1'b0);
        end
        k_rsp_ready = 1'b1;
        k_cmd_valid = 1'b0;
        tick();
        check("bp_idle", busy, 1'b0);
        check("bp_count", op_count, 16'h0001);

        // Timeout: DIV whose done never returns, then a normal ADD.
        k_rsp_ready = 1'b0;
        offer(4'h3, 8'd100, 8'd7, 8'hAA, 8'h55, 1000);
        e = cyc;
        tick();
        k_cmd_valid = 1'b0;
        wait_rsp(60);
        check("to_latency", cyc - e, 2 + TIMEOUT);
        check("to_err", rsp_err, 1'b1);
        check("to_result", rsp_result, 8'h00);
        check("to_flags", rsp_flags, 8'h00);
        k_rsp_ready = 1'b1;
        tick();
        offer(4'h0, 8'h01, 8'h02, 8'h03, 8'h00, 0);
        e = cyc;
        tick();
        k_cmd_valid = 1'b0;
        wait_rsp(10);
        check("post_to_latency", cyc - e, 3);
        check("post_to_err", rsp_err, 1'b0);
        check("post_to_result", rsp_result, 8'h03);
        tick();

        // Reset in the middle of a SQRT wait.
        offer(4'hF, 8'd81, 8'd0, 8'd9, 8'h00, 1000);
        tick();
        k_cmd_valid = 1'b0;
        repeat (5) tick();
        check("sqrt_busy", busy, 1'b1);
        k_reset = 1'b1;
        tick();
        k_reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_alu_op", alu_operation, PARK);
        check("rst_count", op_count, 16'h0000);
        k_idle_done = 1'b0;
        apply();
        #1;
        check("rst_ready_done0", cmd_ready, 1'b0);
        k_idle_done = 1'b1;
        apply();
        #1;
        check("rst_ready_done1", cmd_ready, 1'b1);
        tick();

        // op_count wrap from a preset near the top.
        force dut.r_op_count = 16'hFFFE;
        release dut.r_op_count;
        m_count = 16'hFFFE;
        run_add(8'h10, 8'h20);
        check("wrap_ffff", op_count, 16'hFFFF);
        run_add(8'h30, 8'h40);
        check("wrap_zero", op_count, 16'h0000);

        // Randomized traffic with backpressure, done gaps, timeouts and resets.
        for (int i = 0; i < 6000; i++) begin
            k_reset     = ($urandom_range(0, 299) == 0);
            k_cmd_valid = ($urandom_range(0, 9) < 6);
            k_op        = ($urandom_range(0, 1) == 0) ? 4'h2 + 4'($urandom_range(0, 1)) : 4'($urandom);
            if ($urandom_range(0, 5) == 0) k_op = 4'hF;
            k_a         = 8'($urandom);
            k_b         = 8'($urandom);
            k_res       = 8'($urandom);
            k_flg       = 8'($urandom);
            k_rsp_ready = ($urandom_range(0, 9) < 7);
            k_idle_done = ($urandom_range(0, 9) < 8);
            case ($urandom_range(0, 7))
                0:       k_delay = 0;
                1:       k_delay = 1;
                2:       k_delay = TIMEOUT - 1;
                3:       k_delay = TIMEOUT;
                4:       k_delay = 1000;
                default: k_delay = $urandom_range(2, 12);
            endcase
            tick();
        end

        quiet();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
